// File: rtl/reg_pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// reg_pipe_ctrl_if
//
// Purpose:
//   Groups the sample stream of reg_pipe_ctrl into one bundle. The bundle has
//   an input side (valid/ready/data) and an output side (valid/data).
//
// Parameters:
//   WIDTH      data width in bits
//
// Signals:
//   in_valid   producer -> block   input sample valid
//   in_ready   block -> producer   block accepts a sample this cycle
//   din        producer -> block   input data
//   out_valid  block -> consumer   output sample valid
//   dout       block -> consumer   output data
//
// Modports:
//   master     environment side: drives in_valid/din and observes the rest
//   slave      pipeline side: drives in_ready/out_valid/dout
// ----------------------------------------------------------------------------
interface reg_pipe_ctrl_if #(
    parameter int WIDTH = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic [WIDTH-1:0] dout;

    modport master (
        output in_valid,
        output din,
        input  in_ready,
        input  out_valid,
        input  dout
    );

    modport slave (
        input  in_valid,
        input  din,
        output in_ready,
        output out_valid,
        output dout
    );
endinterface : reg_pipe_ctrl_if

// File: rtl/reg_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// reg_pipe_ctrl
//
// Purpose:
//   Register pipeline with a depth that can be chosen at runtime, from 0
//   (combinational bypass) up to MAX_DEPTH. Each stage carries a valid bit
//   next to its data. When a new depth is requested, the block stops taking
//   input and waits until the samples in flight have left at the old depth.
//   Only then does it switch. This lets the latency of an operand or result
//   path change without corrupting any sample.
//
// Parameters:
//   WIDTH          data width, bits
//   MAX_DEPTH      number of physical stages, >= 1
//   DEFAULT_DEPTH  active depth after reset, 0..MAX_DEPTH
//   DW             derived: width of the depth and level fields
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   ce         clock enable; gates every stage shift, the FSM and the counter
//   sclr       synchronous clear, active-high, acts only when ce=1
//   depth_sel  requested depth; values above MAX_DEPTH clamp to MAX_DEPTH
//   bus        sample stream (in_valid/in_ready/din, out_valid/dout)
//   depth_act  depth currently applied
//   level      number of valid samples in stages 0..depth_act-1
//   stall_cnt  count of cycles in which input was blocked
//
// Build option:
//   REG_PIPE_STALL_CNT_EN
//     When defined, stall_cnt counts enabled cycles in which in_valid=1 and
//     in_ready=0. It saturates at 16'hFFFF and clears only on rst.
//     When undefined, stall_cnt is tied to zero and no counter is built.
// ----------------------------------------------------------------------------
module reg_pipe_ctrl #(
    parameter  int WIDTH         = 18,
    parameter  int MAX_DEPTH     = 4,
    parameter  int DEFAULT_DEPTH = 1,
    localparam int DW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  sclr,
    input  logic [DW-1:0]         depth_sel,
    reg_pipe_ctrl_if.slave        bus,
    output logic [DW-1:0]         depth_act,
    output logic [DW-1:0]         level,
    output logic [15:0]           stall_cnt
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     stg_q [MAX_DEPTH];
    logic [WIDTH-1:0]     stg_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_q;
    logic [MAX_DEPTH-1:0] vld_d;
    state_t               state_q;
    state_t               state_d;
    logic [DW-1:0]        depth_act_q;
    logic [DW-1:0]        depth_act_d;

    logic                 in_ready_c;
    logic                 accept_c;
    logic [DW-1:0]        depth_req_c;
    logic [MAX_DEPTH-1:0] win_vld;
    logic [DW-1:0]        level_c;

    // Requests beyond the physical pipeline saturate rather than wrap.
    function automatic logic [DW-1:0] clamp_depth(input logic [DW-1:0] d);
        return (d > MAX_D) ? MAX_D : d;
    endfunction

    assign depth_req_c = clamp_depth(depth_sel);

    // Input is blocked for the whole drain. No new sample can enter a
    // pipeline whose latency is about to change.
    assign in_ready_c = (state_q == RUN);

    // Stage 0 records acceptance, gated by ready. It is not gated by ce:
    // stage 0 only loads on enabled cycles, so the product is already
    // qualified when it takes effect.
    assign accept_c = bus.in_valid & in_ready_c;

    // ------------------------------------------------------------------
    // Occupancy of the active window. Stages at or beyond depth_act still
    // shift but never reach the output, so they are excluded from level.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_win
            assign win_vld[gi] = vld_q[gi] & (DW'(gi) < depth_act_q);
        end
    endgenerate

    always_comb begin
        level_c = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (win_vld[i]) begin
                level_c = level_c + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: stage shift, clear and depth-change FSM
    // ------------------------------------------------------------------
    always_comb begin
        stg_d       = stg_q;
        vld_d       = vld_q;
        state_d     = state_q;
        depth_act_d = depth_act_q;

        if (ce) begin
            if (sclr) begin
                // The clear drops all samples in flight. No drain is
                // needed, so the requested depth takes effect at once.
                for (int i = 0; i < MAX_DEPTH; i++) begin
                    stg_d[i] = '0;
                end
                vld_d       = '0;
                state_d     = RUN;
                depth_act_d = depth_req_c;
            end else begin
                // All physical stages shift every enabled cycle. Data
                // loads even without a valid sample, so the datapath
                // needs no per-stage enable.
                stg_d[0] = bus.din;
                vld_d[0] = accept_c;
                for (int i = 1; i < MAX_DEPTH; i++) begin
                    stg_d[i] = stg_q[i-1];
                    vld_d[i] = vld_q[i-1];
                end

                unique case (state_q)
                    RUN: begin
                        // A sample accepted in this same cycle is already
                        // in vld_d[0]. It is drained at the old depth.
                        if (depth_req_c != depth_act_q) begin
                            state_d = DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Sample the request only at the moment of the
                        // switch. Changes made while draining just update
                        // what is applied here.
                        if (level_c == '0) begin
                            depth_act_d = depth_req_c;
                            state_d     = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stg_q[i] <= '0;
            end
            vld_q       <= '0;
            state_q     <= RUN;
            depth_act_q <= DEF_D;
        end else begin
            stg_q       <= stg_d;
            vld_q       <= vld_d;
            state_q     <= state_d;
            depth_act_q <= depth_act_d;
        end
    end

    // ------------------------------------------------------------------
    // Output selection. Depth 0 is a pure wire from input to output. At
    // that depth the output valid follows the handshake, so a blocked
    // sample never shows up as valid at the output.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dout_c;
    logic             out_valid_c;

    always_comb begin
        dout_c      = bus.din;
        out_valid_c = accept_c;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (depth_act_q == DW'(i + 1)) begin
                dout_c      = stg_q[i];
                out_valid_c = vld_q[i];
            end
        end
    end

    assign bus.dout      = dout_c;
    assign bus.out_valid = out_valid_c;
    assign bus.in_ready  = in_ready_c;
    assign depth_act     = depth_act_q;
    assign level         = level_c;

    // ------------------------------------------------------------------
    // Backpressure counter
    // ------------------------------------------------------------------
`ifdef REG_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // This counter ignores sclr. It reports the total number of blocked
    // cycles since power-up or reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ce && bus.in_valid && !in_ready_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule : reg_pipe_ctrl

// File: tb/tb_reg_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reg_pipe_ctrl
//
// Directed bench for reg_pipe_ctrl with WIDTH=18, MAX_DEPTH=4, DEFAULT_DEPTH=1.
// Inputs change 1 time unit after the rising edge. Outputs are checked one
// unit later, so every check sees the state of the current cycle.
// The stall counter expectations depend on REG_PIPE_STALL_CNT_EN.
// ----------------------------------------------------------------------------
module tb_reg_pipe_ctrl;

    localparam int WIDTH         = 18;
    localparam int MAX_DEPTH     = 4;
    localparam int DEFAULT_DEPTH = 1;
    localparam int DW            = 3;

`ifdef REG_PIPE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce;
    logic          sclr;
    logic [DW-1:0] depth_sel;
    logic [DW-1:0] depth_act;
    logic [DW-1:0] level;
    logic [15:0]   stall_cnt;

    int total = 0;
    int bad   = 0;

    reg_pipe_ctrl_if #(.WIDTH(WIDTH)) bus ();

    reg_pipe_ctrl #(
        .WIDTH         (WIDTH),
        .MAX_DEPTH     (MAX_DEPTH),
        .DEFAULT_DEPTH (DEFAULT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sclr      (sclr),
        .depth_sel (depth_sel),
        .bus       (bus),
        .depth_act (depth_act),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ce           = 1'b0;
        sclr         = 1'b0;
        depth_sel    = 3'd1;
        bus.in_valid = 1'b0;
        bus.din      = '0;

        // ---------------- 1. reset ----------------
        #2 rst = 1'b0;
        step();
        step();
        chk("rst_dout", bus.dout, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_depth_act", depth_act, 1);
        chk("rst_level", level, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b1;
        step();
        chk("post_rst_depth_act", depth_act, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        // ---------------- 2. depth 2 stream ----------------
        ce = 1'b1; depth_sel = 3'd2; bus.in_valid = 1'b0; #1;
        chk("t2_ready_run", bus.in_ready, 1);
        step();
        #1;
        chk("t2_ready_drain", bus.in_ready, 0);
        chk("t2_depth_old", depth_act, 1);
        step();
        bus.in_valid = 1'b1; bus.din = 18'd5; #1;
        chk("t2_depth_new", depth_act, 2);
        chk("t2_ready_back", bus.in_ready, 1);
        chk("t2_ov_c0", bus.out_valid, 0);
        step();
        bus.din = 18'd6; #1;
        chk("t2_ov_c1", bus.out_valid, 0);
        step();
        bus.din = 18'd7; #1;
        chk("t2_ov_c2", bus.out_valid, 1);
        chk("t2_dout_5", bus.dout, 5);
        step();
        bus.in_valid = 1'b0; #1;
        chk("t2_dout_6", bus.dout, 6);
        chk("t2_level_2", level, 2);
        step();
        #1;
        chk("t2_dout_7", bus.dout, 7);
        chk("t2_ov_7", bus.out_valid, 1);
        chk("t2_level_1", level, 1);
        step();
        #1;
        chk("t2_ov_end", bus.out_valid, 0);
        chk("t2_level_0", level, 0);

        // ---------------- 3. bypass (depth 0) ----------------
        depth_sel = 3'd0;
        step();
        #1;
        chk("t3_ready_drain", bus.in_ready, 0);
        step();
        bus.in_valid = 1'b1; bus.din = 18'h3FFFF; #1;
        chk("t3_depth_act", depth_act, 0);
        chk("t3_dout", bus.dout, 32'h3FFFF);
        chk("t3_ov", bus.out_valid, 1);
        step();
        bus.in_valid = 1'b0; bus.din = 18'h12345; #1;
        chk("t3_ov_idle", bus.out_valid, 0);
        chk("t3_dout_wire", bus.dout, 32'h12345);
        step();

        // ---------------- 4. depth 3 -> 1 with 3 in flight ----------------
        depth_sel = 3'd3; #1;
        step();
        #1;
        chk("t4_ready_drain0", bus.in_ready, 0);
        step();
        bus.in_valid = 1'b1; bus.din = 18'd11; #1;
        chk("t4_depth_3", depth_act, 3);
        chk("t4_ov_stale", bus.out_valid, 0);
        chk("t4_level_0", level, 0);
        step();
        bus.din = 18'd12; #1;
        chk("t4_ov_m1", bus.out_valid, 0);
        step();
        bus.din = 18'd13; #1;
        chk("t4_ov_m2", bus.out_valid, 0);
        step();
        bus.in_valid = 1'b0; depth_sel = 3'd1; #1;
        chk("t4_m3_ov", bus.out_valid, 1);
        chk("t4_m3_dout", bus.dout, 11);
        chk("t4_m3_level", level, 3);
        chk("t4_m3_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b1; bus.din = 18'd99; #1;
        chk("t4_m4_ready", bus.in_ready, 0);
        chk("t4_m4_dout", bus.dout, 12);
        chk("t4_m4_level", level, 2);
        chk("t4_m4_depth", depth_act, 3);
        step();
        #1;
        chk("t4_m5_ready", bus.in_ready, 0);
        chk("t4_m5_dout", bus.dout, 13);
        chk("t4_m5_level", level, 1);
        step();
        #1;
        chk("t4_m6_ready", bus.in_ready, 0);
        chk("t4_m6_ov", bus.out_valid, 0);
        chk("t4_m6_level", level, 0);
        step();
        #1;
        chk("t4_m7_ready", bus.in_ready, 1);
        chk("t4_m7_depth", depth_act, 1);
        chk("t4_m7_ov", bus.out_valid, 0);
        step();
        bus.in_valid = 1'b0; #1;
        chk("t4_m8_ov", bus.out_valid, 1);
        chk("t4_m8_dout", bus.dout, 99);
        chk("t4_stall", stall_cnt, STALL_EN ? 32'd3 : 32'd0);
        step();

        // ---------------- 5. ce low for 4 cycles ----------------
        bus.in_valid = 1'b1; bus.din = 18'd21; #1;
        chk("t5_n0_ov", bus.out_valid, 0);
        step();
        bus.din = 18'd22; #1;
        chk("t5_n1_dout", bus.dout, 21);
        step();
        ce = 1'b0; bus.din = 18'h55; depth_sel = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_frz_dout", bus.dout, 22);
            chk("t5_frz_ov", bus.out_valid, 1);
            chk("t5_frz_level", level, 1);
            chk("t5_frz_ready", bus.in_ready, 1);
            chk("t5_frz_depth", depth_act, 1);
            step();
        end
        ce = 1'b1; depth_sel = 3'd1; bus.in_valid = 1'b0; #1;
        chk("t5_resume_dout", bus.dout, 22);
        chk("t5_resume_ov", bus.out_valid, 1);
        step();

        // ---------------- 6. sclr, clamp and drain stall ----------------
        sclr = 1'b1; depth_sel = 3'd7; #1;
        chk("t6_pre_ov", bus.out_valid, 0);
        chk("t6_pre_level", level, 0);
        step();
        sclr = 1'b0; bus.in_valid = 1'b1; bus.din = 18'd31; #1;
        chk("t6_clamp_depth", depth_act, 4);
        chk("t6_clamp_ready", bus.in_ready, 1);
        step();
        bus.din = 18'd32; #1;
        chk("t6_level_1", level, 1);
        step();
        bus.in_valid = 1'b0; sclr = 1'b1; #1;
        chk("t6_level_2", level, 2);
        step();
        sclr = 1'b0; #1;
        chk("t6_clr_level", level, 0);
        chk("t6_clr_ov", bus.out_valid, 0);
        chk("t6_clr_stall", stall_cnt, STALL_EN ? 32'd3 : 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_dropped_ov", bus.out_valid, 0);
            step();
        end
        // fill depth 4, then request depth 1 and block input while draining
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = 18'(41 + i); #1;
            chk("t6_fill_ov", bus.out_valid, 0);
            step();
        end
        bus.in_valid = 1'b0; depth_sel = 3'd1; #1;
        chk("t6_p4_dout", bus.dout, 41);
        chk("t6_p4_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b1; bus.din = 18'd77; #1;
        chk("t6_p5_ready", bus.in_ready, 0);
        chk("t6_p5_dout", bus.dout, 42);
        chk("t6_p5_level", level, 3);
        step();
        #1;
        chk("t6_p6_dout", bus.dout, 43);
        chk("t6_p6_level", level, 2);
        step();
        #1;
        chk("t6_p7_dout", bus.dout, 44);
        chk("t6_p7_level", level, 1);
        step();
        #1;
        chk("t6_p8_ready", bus.in_ready, 0);
        chk("t6_p8_ov", bus.out_valid, 0);
        step();
        bus.in_valid = 1'b0; #1;
        chk("t6_p9_ready", bus.in_ready, 1);
        chk("t6_p9_depth", depth_act, 1);
        chk("t6_stall_total", stall_cnt, STALL_EN ? 32'd7 : 32'd0);
        step();

        // ---------------- 7. reset in the middle of a drain ----------------
        depth_sel = 3'd3; bus.in_valid = 1'b1; bus.din = 18'd50; #1;
        chk("t7_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0; #1;
        chk("t7_drain_ready", bus.in_ready, 0);
        chk("t7_drain_dout", bus.dout, 50);
        chk("t7_drain_level", level, 1);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_ov", bus.out_valid, 0);
        chk("t7_rst_level", level, 0);
        chk("t7_rst_ready", bus.in_ready, 1);
        chk("t7_rst_depth", depth_act, 1);
        chk("t7_rst_dout", bus.dout, 0);
        chk("t7_rst_stall", stall_cnt, 0);
        #2 rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_pipe_ctrl
